// File: rtl/d_latch_pkg.sv
// Shared constants for the D latch bank: default width and default reset bit.
package d_latch_pkg;

  localparam int   DEFAULT_WIDTH     = 1;
  localparam logic DEFAULT_RESET_BIT = 1'b0;

  // Build a WIDTH-bit reset pattern from the single default reset bit
  function automatic logic [63:0] default_reset_pattern();
    return {64{DEFAULT_RESET_BIT}};
  endfunction

endpackage

// File: rtl/d_latch_core_if.sv
// Data/enable bundle for the D latch bank.
// The q_changed wire exists only when D_LATCH_CHANGE_DET_EN is defined.
import d_latch_pkg::*;

interface d_latch_core_if #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             q_valid;
`ifdef D_LATCH_CHANGE_DET_EN
  logic             q_changed;
`endif

`ifdef D_LATCH_CHANGE_DET_EN
  modport master (output en, output d, input q, input q_valid, input q_changed);
  modport slave  (input en, input d, output q, output q_valid, output q_changed);
`else
  modport master (output en, output d, input q, input q_valid);
  modport slave  (input en, input d, output q, output q_valid);
`endif

endinterface

// File: rtl/d_latch_hold_reg.sv
// Async-reset enabled hold register: captures d whenever en is high at a clk edge,
// and flags (sticky) that a value has been captured since reset.
import d_latch_pkg::*;

module d_latch_hold_reg #(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] hold_q,
  output logic             q_valid
);

  // Capture d on enabled edges; q_valid stays set until the next reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (en) begin
      hold_q  <= d;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/d_latch_core.sv
// D latch bank built from a clocked hold register plus a combinational bypass,
// so timing tools see only flops and a mux rather than a real latch.
// Optional feature: define D_LATCH_CHANGE_DET_EN to add the registered q_changed pulse.
import d_latch_pkg::*;

module d_latch_core #(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = default_reset_pattern()
) (
  input logic             clk,
  input logic             rst,
  d_latch_core_if.slave   bus
);

  logic [WIDTH-1:0] hold_q;
  logic             q_valid;
  logic [WIDTH-1:0] q_mux;

  d_latch_hold_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_hold_reg (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .d       (bus.d),
    .hold_q  (hold_q),
    .q_valid (q_valid)
  );

  // Output mux: reset wins over transparency, transparency wins over the held value
  always_comb begin
    q_mux = hold_q;
    if (rst)         q_mux = RESET_VAL;
    else if (bus.en) q_mux = bus.d;
  end

  assign bus.q       = q_mux;
  assign bus.q_valid = q_valid;

`ifdef D_LATCH_CHANGE_DET_EN
  logic q_changed;

  // Pulse for one cycle after an edge that loaded hold_q with a different value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_changed <= 1'b0;
    else     q_changed <= bus.en && (bus.d != hold_q);
  end

  assign bus.q_changed = q_changed;
`endif

endmodule

// File: tb/tb_d_latch_core.sv
// Directed bench for d_latch_core (WIDTH=1, RESET_VAL=0, clk period 10).
// Outputs are sampled at the falling edge or a few time units after an input change.
`timescale 1ns/1ps
import d_latch_pkg::*;

module tb_d_latch_core;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  d_latch_core_if #(.WIDTH(1)) bus ();

  d_latch_core #(.WIDTH(1), .RESET_VAL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_chg(input string tag, input logic expected);
`ifdef D_LATCH_CHANGE_DET_EN
    check(tag, bus.q_changed, expected);
`else
    if (expected === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    // 1: reset with en=0, d=1
    rst = 1'b1; bus.en = 1'b0; bus.d = 1'b1;
    #2;
    check("rst_q", bus.q, 1'b0);
    check("rst_qv", bus.q_valid, 1'b0);
    @(negedge clk);
    check("rst_q_edge", bus.q, 1'b0);
    check_chg("rst_chg", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_hold_q", bus.q, 1'b0);
    check("rel_qv", bus.q_valid, 1'b0);

    // 2: transparency without a clock edge
    bus.en = 1'b1; bus.d = 1'b0;
    #1 check("transp_d0", bus.q, 1'b0);
    bus.d = 1'b1;
    #1 check("transp_d1", bus.q, 1'b1);
    check("qv_before_edge", bus.q_valid, 1'b0);
    @(negedge clk);
    check("qv_after_edge", bus.q_valid, 1'b1);
    check("q_after_edge", bus.q, 1'b1);
    check_chg("chg_0_to_1", 1'b1);

    // 3: hold 1 while d drops
    bus.en = 1'b0; bus.d = 1'b0;
    #1 check("hold1_now", bus.q, 1'b1);
    @(negedge clk);
    check("hold1_c1", bus.q, 1'b1);
    check_chg("chg_pulse_end", 1'b0);
    @(negedge clk);
    check("hold1_c2", bus.q, 1'b1);
    @(negedge clk);
    check("hold1_c3", bus.q, 1'b1);

    // 6b: recapture the same 1 -> no change pulse
    bus.en = 1'b1; bus.d = 1'b1;
    @(negedge clk);
    check_chg("chg_same_val", 1'b0);
    bus.en = 1'b0;
    @(negedge clk);
    check_chg("chg_same_val2", 1'b0);

    // 4: new value 0 through transparency, then hold it
    bus.en = 1'b1; bus.d = 1'b0;
    #1 check("transp_new0", bus.q, 1'b0);
    @(negedge clk);
    check_chg("chg_1_to_0", 1'b1);
    bus.en = 1'b0;
    #1 check("hold0_now", bus.q, 1'b0);
    @(negedge clk);
    check("hold0_c1", bus.q, 1'b0);
    check("qv_sticky", bus.q_valid, 1'b1);
    check_chg("chg_1_to_0_end", 1'b0);

    // 5: reset mid-transparency
    bus.en = 1'b1; bus.d = 1'b1;
    #1 check("transp_pre_rst", bus.q, 1'b1);
    #1 rst = 1'b1;
    #1 check("rst_mid_q", bus.q, 1'b0);
    check("rst_mid_qv", bus.q_valid, 1'b0);
    @(negedge clk);
    check("rst_over_edge", bus.q, 1'b0);
    bus.en = 1'b0;
    rst = 1'b0;
    #1 check("post_rst_hold", bus.q, 1'b0);
    check("post_rst_qv", bus.q_valid, 1'b0);
    @(negedge clk);
    check("post_rst_hold_edge", bus.q, 1'b0);
    bus.en = 1'b1;
    #1 check("post_rst_transp", bus.q, 1'b1);
    @(negedge clk);
    check("post_rst_qv_set", bus.q_valid, 1'b1);
    check_chg("post_rst_chg", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
